// File: rtl/rename_pkg.sv
// Shared types for the register file / alias table slice.
// Widths here are the defaults the top-level parameters start from.
package rename_pkg;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ROB_TAG_W = 3;
  localparam int DEF_REG_W     = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_REG_W-1:0]     arch_reg_t;
  typedef logic [DEF_ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [DEF_DATA_W-1:0]    reg_data_t;

  typedef struct packed {
    logic      ready;
    reg_data_t value;
    rob_tag_t  tag;
  } src_rsp_t;

endpackage

// File: rtl/rat_src_lookup.sv
// One source operand lookup: x0, older-lane dispatch, commit bypass, busy tag, stored data.
// Purely combinational (zero latency); no backpressure.
module rat_src_lookup
  import rename_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2
) (
  input  logic [$clog2(NUM_REGS)-1:0]               rs,
  input  logic [NUM_REGS-1:0]                       busy,
  input  rob_tag_t  [NUM_REGS-1:0]                  tag,
  input  reg_data_t [NUM_REGS-1:0]                  data,
  input  logic [ISSUE_W-1:0]                        older_dsp,
  input  logic [ISSUE_W-1:0][$clog2(NUM_REGS)-1:0]  iss_rd,
  input  rob_tag_t  [ISSUE_W-1:0]                   iss_rob,
  input  logic [COMMIT_W-1:0]                       cmt_valid,
  input  logic [COMMIT_W-1:0][$clog2(NUM_REGS)-1:0] cmt_rd,
  input  reg_data_t [COMMIT_W-1:0]                  cmt_value,
  input  rob_tag_t  [COMMIT_W-1:0]                  cmt_rob,
  output src_rsp_t                                  rsp
);

  logic      hit_dsp;
  rob_tag_t  dsp_tag;
  logic      hit_cmt;
  reg_data_t cmt_val;

  always_comb begin
    // Ascending scans: the later (younger) matching lane overrides.
    hit_dsp = 1'b0;
    dsp_tag = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (older_dsp[j] && iss_rd[j] == rs) begin
        hit_dsp = 1'b1;
        dsp_tag = iss_rob[j];
      end
    end

    hit_cmt = 1'b0;
    cmt_val = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cmt_valid[k] && cmt_rd[k] == rs && (!busy[rs] || tag[rs] == cmt_rob[k])) begin
        hit_cmt = 1'b1;
        cmt_val = cmt_value[k];
      end
    end

    rsp       = '0;
    rsp.ready = 1'b1;
    if (rs != '0) begin
      if (hit_dsp) begin
        rsp.ready = 1'b0;
        rsp.tag   = dsp_tag;
      end else if (hit_cmt) begin
        rsp.value = cmt_val;
      end else if (busy[rs]) begin
        rsp.ready = 1'b0;
        rsp.tag   = tag[rs];
      end else begin
        rsp.value = data[rs];
      end
    end
  end

endmodule

// File: rtl/regfile_rat_mp.sv
// Multi-ported architectural register file with ROB-tag alias scoreboard.
// Reads combinational (zero latency), updates on next edge; no backpressure.
module regfile_rat_mp
  import rename_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROB_TAG_W = DEF_ROB_TAG_W,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic [ISSUE_W-1:0]                        iss_valid,
  input  logic [ISSUE_W-1:0]                        iss_writes_rd,
  input  logic [ISSUE_W-1:0][$clog2(NUM_REGS)-1:0]  iss_rd,
  input  logic [ISSUE_W-1:0][ROB_TAG_W-1:0]         iss_rob,
  input  logic [ISSUE_W-1:0][$clog2(NUM_REGS)-1:0]  iss_rs1,
  input  logic [ISSUE_W-1:0][$clog2(NUM_REGS)-1:0]  iss_rs2,
  output logic [ISSUE_W-1:0]                        rs1_ready,
  output logic [ISSUE_W-1:0]                        rs2_ready,
  output logic [ISSUE_W-1:0][DATA_W-1:0]            rs1_value,
  output logic [ISSUE_W-1:0][DATA_W-1:0]            rs2_value,
  output logic [ISSUE_W-1:0][ROB_TAG_W-1:0]         rs1_tag,
  output logic [ISSUE_W-1:0][ROB_TAG_W-1:0]         rs2_tag,
  input  logic [COMMIT_W-1:0]                       cmt_valid,
  input  logic [COMMIT_W-1:0][$clog2(NUM_REGS)-1:0] cmt_rd,
  input  logic [COMMIT_W-1:0][DATA_W-1:0]           cmt_value,
  input  logic [COMMIT_W-1:0][ROB_TAG_W-1:0]        cmt_rob
);

  logic [NUM_REGS-1:0][DATA_W-1:0]    data_q;
  logic [NUM_REGS-1:0][ROB_TAG_W-1:0] tag_q;
  logic [NUM_REGS-1:0][ROB_TAG_W-1:0] tag_n;
  logic [NUM_REGS-1:0]                busy_q;
  logic [NUM_REGS-1:0]                busy_n;

  // Commit clears are applied first so a same-cycle dispatch re-tags on top.
  always_comb begin
    busy_n = busy_q;
    tag_n  = tag_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cmt_valid[k] && cmt_rd[k] != '0 && busy_q[cmt_rd[k]] &&
          tag_q[cmt_rd[k]] == cmt_rob[k]) begin
        busy_n[cmt_rd[k]] = 1'b0;
        tag_n[cmt_rd[k]]  = '0;
      end
    end
    if (flush) begin
      busy_n = '0;
      tag_n  = '0;
    end else begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (iss_valid[i] && iss_writes_rd[i] && iss_rd[i] != '0) begin
          busy_n[iss_rd[i]] = 1'b1;
          tag_n[iss_rd[i]]  = iss_rob[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      tag_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (cmt_valid[k] && cmt_rd[k] != '0) begin
          data_q[cmt_rd[k]] <= cmt_value[k];
        end
      end
      tag_q  <= tag_n;
      busy_q <= busy_n;
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    logic [ISSUE_W-1:0] older_dsp;
    src_rsp_t           rsp1;
    src_rsp_t           rsp2;

    assign older_dsp = iss_valid & iss_writes_rd & ISSUE_W'((1 << i) - 1);

    rat_src_lookup #(
      .NUM_REGS (NUM_REGS),
      .ISSUE_W  (ISSUE_W),
      .COMMIT_W (COMMIT_W)
    ) u_rs1 (
      .rs        (iss_rs1[i]),
      .busy      (busy_q),
      .tag       (tag_q),
      .data      (data_q),
      .older_dsp (older_dsp),
      .iss_rd    (iss_rd),
      .iss_rob   (iss_rob),
      .cmt_valid (cmt_valid),
      .cmt_rd    (cmt_rd),
      .cmt_value (cmt_value),
      .cmt_rob   (cmt_rob),
      .rsp       (rsp1)
    );

    rat_src_lookup #(
      .NUM_REGS (NUM_REGS),
      .ISSUE_W  (ISSUE_W),
      .COMMIT_W (COMMIT_W)
    ) u_rs2 (
      .rs        (iss_rs2[i]),
      .busy      (busy_q),
      .tag       (tag_q),
      .data      (data_q),
      .older_dsp (older_dsp),
      .iss_rd    (iss_rd),
      .iss_rob   (iss_rob),
      .cmt_valid (cmt_valid),
      .cmt_rd    (cmt_rd),
      .cmt_value (cmt_value),
      .cmt_rob   (cmt_rob),
      .rsp       (rsp2)
    );

    assign rs1_ready[i] = rsp1.ready;
    assign rs1_value[i] = rsp1.value;
    assign rs1_tag[i]   = rsp1.tag;
    assign rs2_ready[i] = rsp2.ready;
    assign rs2_value[i] = rsp2.value;
    assign rs2_tag[i]   = rsp2.tag;
  end

endmodule
